// File: rtl/inst_decode_pipe.sv
// inst_decode_pipe: elastic RV32I decode stage.
// A combinational decoder feeds a CYCLE_NUM-deep register chain, each stage
// with its own valid bit; the last stage drives every output. The chain
// collapses bubbles, so it sustains one instruction per cycle and absorbs
// downstream backpressure without dropping anything.
// Optional feature: define INST_DECODE_MEXT_EN to decode RV32M (OP, f7=0000001).
module inst_decode_pipe #(
  parameter int cXLEN     = 32,  // only 32 is meaningful
  parameter int CYCLE_NUM = 2    // 1..4 register stages
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [cXLEN-1:0] iInst,
  input  logic [cXLEN-1:0] iCurPC,
  input  logic             iInstValid,
  output logic             oInstReady,
  input  logic             iFlushPipe,
  output logic             oDecValid,
  input  logic             iDecReady,
  output logic [4:0]       oRs1Addr,
  output logic [4:0]       oRs2Addr,
  output logic [4:0]       oRdAddr,
  output logic [2:0]       oF3,
  output logic [6:0]       oF7,
  output logic [6:0]       oOpcode,
  output logic [cXLEN-1:0] oImm,
  output logic [cXLEN-1:0] oCurPc,
  output logic             oLoad,
  output logic             oStore,
  output logic             oBrOp,
  output logic             oIllegal,
  output logic [4:0]       oAritType,
  output logic             oOpRs1,
  output logic             oOpRs2,
  output logic             oOpImm,
  output logic             oOpPc
);

  localparam int LAST = CYCLE_NUM - 1;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [6:0]       opcode;
    logic [cXLEN-1:0] imm;
    logic [cXLEN-1:0] pc;
    logic             load;
    logic             store;
    logic             br;
    logic             illegal;
    logic [4:0]       arit;
    logic             op_rs1;
    logic             op_rs2;
    logic             op_imm;
    logic             op_pc;
  } dec_t;

  // Immediate formats, all sign-extended from bit 31.
  logic [cXLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{(cXLEN-12){iInst[31]}}, iInst[31:20]};
  assign imm_s = {{(cXLEN-12){iInst[31]}}, iInst[31:25], iInst[11:7]};
  assign imm_b = {{(cXLEN-13){iInst[31]}}, iInst[31], iInst[7], iInst[30:25], iInst[11:8], 1'b0};
  assign imm_u = {iInst[31:12], 12'b0};
  assign imm_j = {{(cXLEN-21){iInst[31]}}, iInst[31], iInst[19:12], iInst[20], iInst[30:21], 1'b0};

  dec_t dec_w;

  // Combinational decode of the offered instruction word.
  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred.
    dec_w        = '0;
    dec_w.rs1    = iInst[19:15];
    dec_w.rs2    = iInst[24:20];
    dec_w.rd     = iInst[11:7];
    dec_w.f3     = iInst[14:12];
    dec_w.f7     = iInst[31:25];
    dec_w.opcode = iInst[6:0];
    dec_w.pc     = iCurPC;
    case (iInst[6:0])
      OPC_OP: begin
        if (iInst[31:25] == 7'b0000000 || iInst[31:25] == 7'b0100000) begin
          dec_w.op_rs1 = 1'b1;
          dec_w.op_rs2 = 1'b1;
          dec_w.arit   = {1'b0, iInst[30], iInst[14:12]};
`ifdef INST_DECODE_MEXT_EN
        end else if (iInst[31:25] == 7'b0000001) begin
          dec_w.op_rs1 = 1'b1;
          dec_w.op_rs2 = 1'b1;
          dec_w.arit   = {1'b1, 1'b0, iInst[14:12]};
`endif
        end else begin
          dec_w.illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_w.imm    = imm_i;
        dec_w.op_rs1 = 1'b1;
        dec_w.op_imm = 1'b1;
        // Only SRAI/SRLI use f7[5] as an operation selector.
        dec_w.arit   = {1'b0, (iInst[14:12] == 3'b101) & iInst[30], iInst[14:12]};
      end
      OPC_LOAD: begin
        dec_w.imm    = imm_i;
        dec_w.op_rs1 = 1'b1;
        dec_w.op_imm = 1'b1;
        dec_w.load   = 1'b1;
      end
      OPC_JALR: begin
        dec_w.imm    = imm_i;
        dec_w.op_rs1 = 1'b1;
        dec_w.op_imm = 1'b1;
        dec_w.br     = 1'b1;
      end
      OPC_STORE: begin
        dec_w.imm    = imm_s;
        dec_w.op_rs1 = 1'b1;
        dec_w.op_imm = 1'b1;
        dec_w.store  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_w.imm    = imm_b;
        dec_w.op_rs1 = 1'b1;
        dec_w.op_rs2 = 1'b1;
        dec_w.br     = 1'b1;
      end
      OPC_LUI: begin
        dec_w.imm    = imm_u;
        dec_w.op_imm = 1'b1;
      end
      OPC_AUIPC: begin
        dec_w.imm    = imm_u;
        dec_w.op_pc  = 1'b1;
        dec_w.op_imm = 1'b1;
      end
      OPC_JAL: begin
        dec_w.imm    = imm_j;
        dec_w.op_pc  = 1'b1;
        dec_w.br     = 1'b1;
      end
      default: dec_w.illegal = 1'b1;
    endcase
  end

  dec_t                 stage_q [CYCLE_NUM];
  logic [CYCLE_NUM-1:0] vld_q;
  logic [CYCLE_NUM-1:0] adv;
  logic [CYCLE_NUM-1:0] in_vld;
  dec_t                 in_dat  [CYCLE_NUM];

  // Advance chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    logic nxt;
    nxt       = !vld_q[LAST] || iDecReady;
    adv       = '0;
    adv[LAST] = nxt;
    for (int k = CYCLE_NUM - 2; k >= 0; k--) begin
      nxt    = !vld_q[k] || nxt;
      adv[k] = nxt;
    end
  end

  // Per-stage input: stage 0 takes the decoder, later stages their predecessor.
  always_comb begin
    in_vld[0] = iInstValid;
    in_dat[0] = dec_w;
    for (int k = 1; k < CYCLE_NUM; k++) begin
      in_vld[k] = vld_q[k-1];
      in_dat[k] = stage_q[k-1];
    end
  end

  // Stage registers: flush clears valids, data loads only on a valid advance.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      vld_q <= '0;
      // NOTE: data stages are reset too, since the outputs must read 0 after reset.
      for (int k = 0; k < CYCLE_NUM; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < CYCLE_NUM; k++) begin
        // NOTE: state uses non-blocking assignment so every stage sees pre-edge values.
        if (iFlushPipe)  vld_q[k] <= 1'b0;
        else if (adv[k]) vld_q[k] <= in_vld[k];
        if (adv[k] && in_vld[k]) stage_q[k] <= in_dat[k];
      end
    end
  end

  assign oInstReady = adv[0] || iFlushPipe;
  assign oDecValid  = vld_q[LAST];
  assign oRs1Addr   = stage_q[LAST].rs1;
  assign oRs2Addr   = stage_q[LAST].rs2;
  assign oRdAddr    = stage_q[LAST].rd;
  assign oF3        = stage_q[LAST].f3;
  assign oF7        = stage_q[LAST].f7;
  assign oOpcode    = stage_q[LAST].opcode;
  assign oImm       = stage_q[LAST].imm;
  assign oCurPc     = stage_q[LAST].pc;
  assign oLoad      = stage_q[LAST].load;
  assign oStore     = stage_q[LAST].store;
  assign oBrOp      = stage_q[LAST].br;
  assign oIllegal   = stage_q[LAST].illegal;
  assign oAritType  = stage_q[LAST].arit;
  assign oOpRs1     = stage_q[LAST].op_rs1;
  assign oOpRs2     = stage_q[LAST].op_rs2;
  assign oOpImm     = stage_q[LAST].op_imm;
  assign oOpPc      = stage_q[LAST].op_pc;

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Bench for inst_decode_pipe: three instances (CYCLE_NUM = 1, 2, 4) share one
// stimulus stream. Each instance is tracked by a transaction-level model: a
// queue of accepted instructions with their age in cycles; the oldest one is
// due at the output once its age reaches CYCLE_NUM-1.
module tb_inst_decode_pipe;

`ifdef INST_DECODE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        iRst = 1'b0;
  logic [31:0] iInst = '0;
  logic [31:0] iCurPC = '0;
  logic        iInstValid = 1'b0;
  logic        iFlushPipe = 1'b0;
  logic        iDecReady = 1'b1;

  logic [4:0]  rs1_o [3], rs2_o [3], rd_o [3];
  logic [2:0]  f3_o [3];
  logic [6:0]  f7_o [3], opc_o [3];
  logic [31:0] imm_o [3], pc_o [3];
  logic        load_o [3], store_o [3], br_o [3], ill_o [3];
  logic [4:0]  arit_o [3];
  logic        ors1_o [3], ors2_o [3], oimm_o [3], opcs_o [3];
  logic        rdy_o [3], dv_o [3];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int N = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    inst_decode_pipe #(.cXLEN(32), .CYCLE_NUM(N)) u_dut (
      .iClk(clk), .iRst(iRst), .iInst(iInst), .iCurPC(iCurPC),
      .iInstValid(iInstValid), .oInstReady(rdy_o[g]), .iFlushPipe(iFlushPipe),
      .oDecValid(dv_o[g]), .iDecReady(iDecReady),
      .oRs1Addr(rs1_o[g]), .oRs2Addr(rs2_o[g]), .oRdAddr(rd_o[g]),
      .oF3(f3_o[g]), .oF7(f7_o[g]), .oOpcode(opc_o[g]),
      .oImm(imm_o[g]), .oCurPc(pc_o[g]),
      .oLoad(load_o[g]), .oStore(store_o[g]), .oBrOp(br_o[g]), .oIllegal(ill_o[g]),
      .oAritType(arit_o[g]),
      .oOpRs1(ors1_o[g]), .oOpRs2(ors2_o[g]), .oOpImm(oimm_o[g]), .oOpPc(opcs_o[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int n_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  function automatic logic [108:0] out_vec(input int g);
    return {rs1_o[g], rs2_o[g], rd_o[g], f3_o[g], f7_o[g], opc_o[g], imm_o[g], pc_o[g],
            load_o[g], store_o[g], br_o[g], ill_o[g], arit_o[g],
            ors1_o[g], ors2_o[g], oimm_o[g], opcs_o[g]};
  endfunction

  // Reference decode written from the ISA rules with signed arithmetic.
  function automatic logic [108:0] model_dec(input logic [31:0] w, input logic [31:0] pc);
    int          s;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic        ld, st, br, ill, r1, r2, im, pcs;
    logic [4:0]  ar;
    s   = $signed(w);
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    imm = 0; ld = 0; st = 0; br = 0; ill = 0; r1 = 0; r2 = 0; im = 0; pcs = 0; ar = 0;
    case (opc)
      7'h33: begin
        if (f7 == 7'd0 || f7 == 7'd32) begin
          r1 = 1; r2 = 1; ar = 5'((f7 == 7'd32) ? 8 + f3 : f3);
        end else if (MEXT && f7 == 7'd1) begin
          r1 = 1; r2 = 1; ar = 5'(16 + f3);
        end else ill = 1;
      end
      7'h13: begin
        imm = 32'(s >>> 20); r1 = 1; im = 1;
        ar = 5'((f3 == 3'd5 && f7 == 7'd32) ? 8 + f3 : f3);
        if (f3 == 3'd5 && f7[5]) ar = 5'(8 + f3);
      end
      7'h03: begin imm = 32'(s >>> 20); r1 = 1; im = 1; ld = 1; end
      7'h67: begin imm = 32'(s >>> 20); r1 = 1; im = 1; br = 1; end
      7'h23: begin
        imm = 32'((s >>> 25) * 32) | 32'(w[11:7]); r1 = 1; im = 1; st = 1;
      end
      7'h63: begin
        imm = 32'((s >>> 31) * 4096) + 32'(w[7]) * 2048 + 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2;
        r1 = 1; r2 = 1; br = 1;
      end
      7'h37: begin imm = w & 32'hFFFFF000; im = 1; end
      7'h17: begin imm = w & 32'hFFFFF000; im = 1; pcs = 1; end
      7'h6F: begin
        imm = 32'((s >>> 31) * 1048576) + 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048 + 32'(w[30:21]) * 2;
        pcs = 1; br = 1;
      end
      default: ill = 1;
    endcase
    return {w[19:15], w[24:20], w[11:7], f3, f7, opc, imm, pc, ld, st, br, ill, ar, r1, r2, im, pcs};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [6:0]  f7s  [4] = '{7'h00, 7'h20, 7'h01, 7'h7F};
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) w[6:0] = opcs[k];
    if (k == 0) w[31:25] = f7s[$urandom_range(0, 3)];
    if (k == 9) w[31:25] = f7s[$urandom_range(0, 3)];
    if (k == 9) w[6:0] = 7'h33;
    return w;
  endfunction

  typedef struct {
    logic [108:0] d;
    int           age;
  } entry_t;

  entry_t mq [3][$];
  bit     live [3] = '{0, 0, 0};
  bit     post_rst [3] = '{0, 0, 0};
  int     deliv [3] = '{0, 0, 0};

  // Model and per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      int   n;
      logic ev, er;
      n  = n_of(g);
      ev = (mq[g].size() > 0) && (mq[g][0].age >= n - 1);
      er = (mq[g].size() < n) || iDecReady || iFlushPipe;
      if (live[g]) begin
        if (post_rst[g]) check($sformatf("n%0d_rst_data", n), 128'(out_vec(g)), 128'd0);
        check($sformatf("n%0d_dec_valid", n), 128'(dv_o[g]), 128'(ev));
        if (ev && dv_o[g]) check($sformatf("n%0d_data", n), 128'(out_vec(g)), 128'(mq[g][0].d));
        if (iRst) check($sformatf("n%0d_inst_ready", n), 128'(rdy_o[g]), 128'(er));
      end
      // Apply what the coming edge does.
      if (!iRst) begin
        mq[g].delete();
        live[g]     = 1;
        post_rst[g] = 1;
      end else begin
        post_rst[g] = 0;
        if (ev && iDecReady) begin
          void'(mq[g].pop_front());
          deliv[g]++;
        end
        if (iFlushPipe) mq[g].delete();
        else begin
          for (int i = 0; i < mq[g].size(); i++) mq[g][i].age++;
          if (iInstValid && er) mq[g].push_back('{model_dec(iInst, iCurPC), 0});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction, wait for the CYCLE_NUM=2 instance to accept it and
  // then to present it; returns the cycles between acceptance and visibility.
  task automatic send_one(input logic [31:0] w, input logic [31:0] pc, output int lat);
    logic acc, found;
    iInst = w; iCurPC = pc; iInstValid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = rdy_o[1];
      if (!acc) tick();
    end
    check("send_accept", 128'(acc), 128'd1);
    tick();
    iInstValid = 1'b0;
    found = 0; lat = 0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (dv_o[1]) begin found = 1; lat = i; end
    end
    check("send_visible", 128'(found), 128'd1);
  endtask

  initial begin
    int   lat, idx, cyc, d0;
    logic fell;

    // Reset with a transfer offered during reset; it must be ignored.
    iInst = 32'h002081B3; iInstValid = 1'b1; iCurPC = 32'h40;
    repeat (10) tick();
    iRst = 1'b1; iInstValid = 1'b0;
    repeat (3) tick();

    // ADD x3,x1,x2 at PC 0x100.
    send_one(32'h002081B3, 32'h100, lat);
    check("add_latency", 128'(lat), 128'd2);
    check("add_rs1", 128'(rs1_o[1]), 128'd1);
    check("add_rs2", 128'(rs2_o[1]), 128'd2);
    check("add_rd", 128'(rd_o[1]), 128'd3);
    check("add_arit", 128'(arit_o[1]), 128'd0);
    check("add_ops", 128'({ors1_o[1], ors2_o[1]}), 128'b11);
    check("add_pc", 128'(pc_o[1]), 128'h100);
    tick(); tick();

    send_one(32'hFFF00093, 32'h104, lat);
    check("addi_imm", 128'(imm_o[1]), 128'hFFFFFFFF);
    check("addi_opimm", 128'(oimm_o[1]), 128'd1);
    tick(); tick();

    send_one(32'h00208463, 32'h108, lat);
    check("beq_imm", 128'(imm_o[1]), 128'd8);
    check("beq_brop", 128'(br_o[1]), 128'd1);
    tick(); tick();

    send_one(32'h0000007F, 32'h10C, lat);
    check("ill_flag", 128'(ill_o[1]), 128'd1);
    check("ill_flags_zero", 128'({load_o[1], store_o[1], br_o[1], ors1_o[1], ors2_o[1],
                                  oimm_o[1], opcs_o[1], arit_o[1]}), 128'd0);
    tick(); tick();

    send_one(32'h022081B3, 32'h110, lat);
    if (MEXT) begin
      check("mul_arit", 128'(arit_o[1]), 128'h10);
      check("mul_legal", 128'(ill_o[1]), 128'd0);
    end else begin
      check("mul_illegal", 128'(ill_o[1]), 128'd1);
    end
    tick(); tick();

    // Backpressure: 20 back-to-back instructions, downstream stalled in cycles 5-9.
    d0 = deliv[1]; idx = 0; cyc = 0; fell = 0;
    while (idx < 20 && cyc < 200) begin
      iDecReady  = !(cyc >= 5 && cyc <= 9);
      iInstValid = 1'b1;
      iInst      = rand_inst();
      iCurPC     = 32'h1000 + 32'(idx) * 4;
      @(negedge clk);
      if (!rdy_o[1]) fell = 1;
      if (rdy_o[1]) idx++;
      tick();
      cyc++;
    end
    iInstValid = 1'b0; iDecReady = 1'b1;
    repeat (8) tick();
    check("bp_ready_fell", 128'(fell), 128'd1);
    check("bp_delivered", 128'(deliv[1] - d0), 128'd20);

    // Flush with two in flight and a third offered.
    iDecReady = 1'b0; iInstValid = 1'b1;
    iInst = 32'h00100093; iCurPC = 32'h200; tick();
    iInst = 32'h00200113; iCurPC = 32'h204; tick();
    iInst = 32'h00300193; iCurPC = 32'h208; iFlushPipe = 1'b1; tick();
    iFlushPipe = 1'b0; iInstValid = 1'b0; iDecReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_empty", 128'(dv_o[1]), 128'd0);
      tick();
    end
    send_one(32'h00400213, 32'h20C, lat);
    check("post_flush_latency", 128'(lat), 128'd2);
    check("post_flush_pc", 128'(pc_o[1]), 128'h20C);
    tick(); tick();

    // Randomized traffic with flushes and one mid-stream reset.
    for (int c = 0; c < 3000; c++) begin
      iInstValid = ($urandom_range(0, 3) != 0);
      iInst      = rand_inst();
      iCurPC     = $urandom & 32'hFFFFFFFC;
      iDecReady  = ($urandom_range(0, 3) != 0);
      iFlushPipe = ($urandom_range(0, 39) == 0);
      iRst       = !(c == 1500 || c == 1501);
      tick();
    end
    iInstValid = 1'b0; iFlushPipe = 1'b0; iDecReady = 1'b1; iRst = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
